// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - shared opcode enum and default width for the logic pipe
package logic_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

endpackage

// File: rtl/logic_alu.sv
// rtl/logic_alu.sv - combinational bitwise operation unit between S1 and S2
module logic_alu
  import logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/logic_pipe.sv
// rtl/logic_pipe.sv - two-stage valid/ready bitwise logic pipeline with delivery counter
module logic_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [7:0]       op_count
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [7:0]       r_op_count;

  logic             w_s1_adv;
  logic             w_accept;
  logic             w_deliver;
  logic [WIDTH-1:0] w_y;

  // S1 may move on whenever S2 is empty or is being drained this cycle
  assign w_s1_adv  = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = r_out_valid && out_ready;

  logic_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (r_s1_a),
    .b  (r_s1_b),
    .op (r_s1_op),
    .y  (w_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s1_op    <= op;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_result    <= w_y;
      r_zero      <= (w_y == '0);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= 8'd0;
    end else if (w_deliver) begin
      r_op_count <= r_op_count + 8'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_logic_pipe.sv
// tb/tb_logic_pipe.sv - directed self-checking bench for logic_pipe
module tb_logic_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic [2:0] op = 3'b000;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] result;
  logic       zero;
  logic [7:0] op_count;

  int n_pass = 0;
  int n_total = 0;

  logic_pipe #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    a = 4'bxxxx;
    b = 4'bxxxx;
    op = 3'bxxx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_total++;
    if ({out_valid, result, zero, op_count} !== 14'd0) $display("FAIL reset_outputs: got ov=%0b res=%0h z=%0b cnt=%0d required all 0", out_valid, result, zero, op_count);
    else n_pass++;
    step();
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_nor_zero();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 4'b0110; b = 4'b1001; op = 3'b011;
    step();
    idle_inputs();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL nor_latency_early: got out_valid=%0b required 0", out_valid);
    else n_pass++;
    step();
    n_total++;
    if ({out_valid, result, zero} !== {1'b1, 4'b0000, 1'b1}) $display("FAIL nor_result: got ov=%0b res=%b z=%0b required ov=1 res=0000 z=1", out_valid, result, zero);
    else n_pass++;
    step();
    n_total++;
    if ({out_valid, op_count} !== {1'b0, 8'd1}) $display("FAIL nor_count: got ov=%0b cnt=%0d required ov=0 cnt=1", out_valid, op_count);
    else n_pass++;
  endtask

  task automatic test_nor_and();
    in_valid = 1'b1; a = 4'b0000; b = 4'b0000; op = 3'b011;
    step();
    a = 4'b1100; b = 4'b1010; op = 3'b000;
    step();
    idle_inputs();
    n_total++;
    if ({out_valid, result, zero} !== {1'b1, 4'b1111, 1'b0}) $display("FAIL nor_ones: got ov=%0b res=%b z=%0b required ov=1 res=1111 z=0", out_valid, result, zero);
    else n_pass++;
    step();
    n_total++;
    if ({out_valid, result, zero} !== {1'b1, 4'b1000, 1'b0}) $display("FAIL and_result: got ov=%0b res=%b z=%0b required ov=1 res=1000 z=0", out_valid, result, zero);
    else n_pass++;
    step();
    n_total++;
    if ({out_valid, op_count} !== {1'b0, 8'd3}) $display("FAIL and_count: got ov=%0b cnt=%0d required ov=0 cnt=3", out_valid, op_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_res [8];
    exp_res[0] = 4'b0001; exp_res[1] = 4'b0111; exp_res[2] = 4'b0110; exp_res[3] = 4'b1000;
    exp_res[4] = 4'b1110; exp_res[5] = 4'b1001; exp_res[6] = 4'b1010; exp_res[7] = 4'b0101;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        in_valid = 1'b1; a = 4'b0101; b = 4'b0011; op = 3'(i);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL b2b_in_ready_%0d: got %0b required 1", i, in_ready);
        else n_pass++;
      end else begin
        idle_inputs();
      end
      if (i >= 2) begin
        n_total++;
        if ({out_valid, result} !== {1'b1, exp_res[i-2]}) $display("FAIL b2b_result_%0d: got ov=%0b res=%b required ov=1 res=%b", i - 2, out_valid, result, exp_res[i-2]);
        else n_pass++;
      end
      step();
    end
    n_total++;
    if ({out_valid, op_count} !== {1'b0, 8'd11}) $display("FAIL b2b_count: got ov=%0b cnt=%0d required ov=0 cnt=11", out_valid, op_count);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [3:0] exp_res [3];
    logic [3:0] got [$];
    int next_op = 0;
    exp_res[0] = 4'b0001; exp_res[1] = 4'b0111; exp_res[2] = 4'b0110;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) out_ready = 1'b1;
      if (next_op < 3) begin
        in_valid = 1'b1; a = 4'b0101; b = 4'b0011; op = 3'(next_op);
      end else begin
        idle_inputs();
      end
      #1;
      if (i >= 2 && i <= 4) begin
        n_total++;
        if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 4'b0001} || next_op != 2)
          $display("FAIL stall_hold_%0d: got rdy=%0b ov=%0b res=%b accepted=%0d required rdy=0 ov=1 res=0001 accepted=2", i, in_ready, out_valid, result, next_op);
        else n_pass++;
      end
      if (out_valid && out_ready) got.push_back(result);
      if (in_valid && in_ready) next_op++;
      step();
    end
    n_total++;
    if (got.size() != 3) $display("FAIL stall_delivered: got %0d results required 3", got.size());
    else n_pass++;
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      n_total++;
      if (got[k] !== exp_res[k]) $display("FAIL stall_order_%0d: got %b required %b", k, got[k], exp_res[k]);
      else n_pass++;
    end
    n_total++;
    if ({out_valid, op_count} !== {1'b0, 8'd14}) $display("FAIL stall_count: got ov=%0b cnt=%0d required ov=0 cnt=14", out_valid, op_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; a = 4'b1111; b = 4'b0000; op = 3'b001;
    step();
    step();
    idle_inputs();
    n_total++;
    if ({out_valid, in_ready} !== {1'b1, 1'b0}) $display("FAIL midrst_full: got ov=%0b rdy=%0b required ov=1 rdy=0", out_valid, in_ready);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if ({out_valid, op_count} !== {1'b0, 8'd0}) $display("FAIL midrst_clear: got ov=%0b cnt=%0d required ov=0 cnt=0", out_valid, op_count);
    else n_pass++;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0) stale++;
      step();
    end
    n_total++;
    if (stale != 0 || op_count !== 8'd0) $display("FAIL midrst_stale: got %0d stale cycles cnt=%0d required 0 and 0", stale, op_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      if (i < 256) begin
        in_valid = 1'b1; a = 4'(i); b = 4'b0000; op = 3'b111;
      end else begin
        idle_inputs();
      end
      step();
    end
    n_total++;
    if ({out_valid, op_count} !== {1'b1, 8'd255}) $display("FAIL wrap_255: got ov=%0b cnt=%0d required ov=1 cnt=255", out_valid, op_count);
    else n_pass++;
    step();
    n_total++;
    if ({out_valid, op_count} !== {1'b0, 8'd0}) $display("FAIL wrap_0: got ov=%0b cnt=%0d required ov=0 cnt=0", out_valid, op_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nor_zero();
    test_nor_and();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
